pu_riscv_ram_queue_prog: RTL
============================

# pu_riscv_ram_queue_prog

Parametrised fall-through queue for the memory subsystem, the successor to the core's fixed-threshold queue.
- Circular buffer of any DEPTH, not only powers of two.
- Exposes live occupancy; almost-empty/almost-full thresholds are programmable at run time.
- Defined simultaneous read/write at the full and empty boundaries.
- Sticky overflow/underflow error flags.
- Sits between the AHB-Lite bus interface and the instruction/data memory pipelines as a request/response buffer.

## Interface
- DEPTH, 8: number of entries, ≥ 2, any integer.
- DBITS, 64: data width.
- CBITS (localparam), $clog2(DEPTH+1): width of count and threshold values.

Ports:
- clk_i  in  1  rising-edge clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- clr_i  in  1  synchronous clear of queue contents and status.
- ena_i  in  1  clock enable for queue operations.
- we_i  in  1  write request.
- d_i  in  DBITS  write data.
- re_i  in  1  read request; pops the head.
- q_o  out  DBITS  head entry, fall-through; 0 when empty.
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.
- almost_empty_o  out  1  count ≤ aempty_thr_i.
- almost_full_o  out  1  count ≥ afull_thr_i.
- aempty_thr_i  in  CBITS  almost-empty threshold.
- afull_thr_i  in  CBITS  almost-full threshold.
- count_o  out  CBITS  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a write was rejected.
- underflow_o  out  1  sticky: a read was rejected.
- err_clr_i  in  1  synchronous clear of the sticky error flags.

## Operation
- Storage: DEPTH×DBITS array with read pointer rp and write pointer wp, each 0..DEPTH-1.
  - A pointer at DEPTH-1 wraps to 0 on increment; no modulo-2^n assumption.
- Accept rules, evaluated only when ena_i=1:
  - wr_ok = we_i & (~full_o | re_i).
  - rd_ok = re_i & ~empty_o.
- Full and empty boundaries:
  - we_i & re_i while full: both accepted, count unchanged, no overflow.
  - we_i & re_i while empty: write accepted, read rejected, underflow set, count becomes 1.
- wr_ok: mem[wp] ← d_i, wp advances.
- rd_ok: rp advances.
- Count: count_next = count + wr_ok − rd_ok.
- q_o = mem[rp] combinationally when count ≠ 0, otherwise 0. A written word is visible on q_o the cycle after the write.
- Status flags are registered. Every clock they are recomputed from count_next and the current thresholds, even when ena_i=0, so a threshold change takes effect one cycle later.
- Thresholds are unsigned:
  - aempty_thr_i ≥ DEPTH forces almost_empty_o to 1.
  - afull_thr_i = 0 forces almost_full_o to 1.
- Errors, when ena_i=1:
  - overflow_o is set by we_i & full_o & ~re_i.
  - underflow_o is set by re_i & empty_o.
  - err_clr_i clears both flags. A set in the same cycle wins over err_clr_i.
- Priority: rst_i > clr_i > ena_i.
  - clr_i zeroes rp, wp and count; empty_o=1, full_o=0; almost flags are recomputed for count 0.
  - clr_i does not touch the error flags or the array contents.
- ena_i=0: pointers, count and error flags hold; inputs are ignored.

## Timing
- Reset values:
  - rp = wp = count_o = 0.
  - empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
  - overflow_o=0, underflow_o=0, q_o=0.
  - Array contents are undefined but masked by the empty condition.
- Asynchronous assertion of rst_i mid-operation discards all entries immediately.
- The first clock after deassertion recomputes the almost flags from the thresholds.
- Write to q_o latency: 1 cycle (write at edge N, visible after edge N).
- Read: the head is valid in the same cycle re_i is sampled; the next entry appears after the edge.
- count_o, the flags and the error bits all change on the same edge as the accepted operation.
- No combinational path from we_i or re_i to any output. q_o depends only on registered state.

## Test plan
- Non-power-of-two fill and wrap:
  - DEPTH=5; write 1..5 → full_o=1, count_o=5.
  - Read 3 → q_o 1,2,3, count_o=2.
  - Write 6,7,8 with wp wrapping → reads return 4,5,6,7,8 in order, then empty_o=1, q_o=0.
- Boundary simultaneous operations:
  - Full plus we&re with d=0xAA → count stays 5, no overflow, 0xAA returned last.
  - Empty plus we&re with d=0x55 → count_o=1, q_o=0x55, underflow_o=1.
- Thresholds:
  - aempty_thr=1, afull_thr=4, DEPTH=5: step count 0→5→0 → almost_empty_o=1 only at counts 0,1; almost_full_o=1 only at counts 4,5.
  - Change afull_thr to 2 at count 3 → almost_full_o rises next cycle.
- Errors:
  - Write while full → overflow_o=1, count unchanged, data unchanged; flag persists across clr_i.
  - err_clr_i together with a new overflow → flag stays 1.
  - err_clr_i alone → flag drops to 0.
- Enable and clear:
  - ena_i=0 with we_i=re_i=1 for 3 cycles → no state change.
  - clr_i at count 3 → count_o=0, empty_o=1 next edge.
  - clr_i together with we_i → the write is dropped.
- Asynchronous reset mid-burst:
  - Assert rst_i between edges at count 4 → all outputs go to reset values before the next edge.
  - After release, the first write is read back correctly.

Source files
------------

// File: rtl/pu_riscv_ram_queue_prog_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pu_riscv_ram_queue_prog_if : control, data and status bundle of the queue
// Revision: 1.0
// ----------------------------------------------------------------------------
interface pu_riscv_ram_queue_prog_if #(
  parameter int DEPTH = 8,
  parameter int DBITS = 64
);
  localparam int CBITS = $clog2(DEPTH + 1);

  logic             clr_i;
  logic             ena_i;
  logic             we_i;
  logic [DBITS-1:0] d_i;
  logic             re_i;
  logic [DBITS-1:0] q_o;
  logic             empty_o;
  logic             full_o;
  logic             almost_empty_o;
  logic             almost_full_o;
  logic [CBITS-1:0] aempty_thr_i;
  logic [CBITS-1:0] afull_thr_i;
  logic [CBITS-1:0] count_o;
  logic             overflow_o;
  logic             underflow_o;
  logic             err_clr_i;

  modport master (
    output clr_i, ena_i, we_i, d_i, re_i, aempty_thr_i, afull_thr_i, err_clr_i,
    input  q_o, empty_o, full_o, almost_empty_o, almost_full_o, count_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, ena_i, we_i, d_i, re_i, aempty_thr_i, afull_thr_i, err_clr_i,
    output q_o, empty_o, full_o, almost_empty_o, almost_full_o, count_o,
           overflow_o, underflow_o
  );
endinterface
`default_nettype wire

// File: rtl/pu_riscv_ram_queue_prog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pu_riscv_ram_queue_prog : fall-through queue, any DEPTH, programmable flags
// Revision: 1.0
// ----------------------------------------------------------------------------
module pu_riscv_ram_queue_prog #(
  parameter int DEPTH = 8,
  parameter int DBITS = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  pu_riscv_ram_queue_prog_if.slave bus
);
  localparam int CBITS = $clog2(DEPTH + 1);
  localparam int PBITS = $clog2(DEPTH);
  localparam logic [CBITS-1:0] DEPTH_C  = CBITS'(DEPTH);
  localparam logic [PBITS-1:0] PTR_LAST = PBITS'(DEPTH - 1);

  logic [DBITS-1:0] mem [DEPTH];
  logic [PBITS-1:0] rp, wp;
  logic [CBITS-1:0] count, count_next;
  logic             empty, full, aempty, afull, ovf, unf;
  logic             op_en, wr_ok, rd_ok, set_ovf, set_unf;

  // clr_i outranks ena_i, so it also masks the accept and error terms
  always_comb begin
    op_en   = bus.ena_i & ~bus.clr_i;
    wr_ok   = op_en & bus.we_i & (~full | bus.re_i);
    rd_ok   = op_en & bus.re_i & ~empty;
    set_ovf = op_en & bus.we_i & full & ~bus.re_i;
    set_unf = op_en & bus.re_i & empty;
    if (bus.clr_i)
      count_next = '0;
    else
      count_next = count + CBITS'(wr_ok) - CBITS'(rd_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rp     <= '0;
      wp     <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      aempty <= 1'b1;
      afull  <= 1'b0;
    end else begin
      if (bus.clr_i) begin
        rp <= '0;
        wp <= '0;
      end else begin
        if (wr_ok) wp <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
        if (rd_ok) rp <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
      end
      count  <= count_next;
      empty  <= (count_next == '0);
      full   <= (count_next == DEPTH_C);
      aempty <= (bus.aempty_thr_i >= DEPTH_C) | (count_next <= bus.aempty_thr_i);
      afull  <= (bus.afull_thr_i == '0) | (count_next >= bus.afull_thr_i);
    end
  end

  // A flag being set in the same cycle as err_clr_i stays set
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (set_ovf)                    ovf <= 1'b1;
      else if (op_en & bus.err_clr_i) ovf <= 1'b0;
      if (set_unf)                    unf <= 1'b1;
      else if (op_en & bus.err_clr_i) unf <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wp] <= bus.d_i;
  end

  assign bus.q_o            = (count != '0) ? mem[rp] : '0;
  assign bus.count_o        = count;
  assign bus.empty_o        = empty;
  assign bus.full_o         = full;
  assign bus.almost_empty_o = aempty;
  assign bus.almost_full_o  = afull;
  assign bus.overflow_o     = ovf;
  assign bus.underflow_o    = unf;

endmodule
`default_nettype wire
